// File: rtl/hex_inverter_bist_pkg.sv
// Shared definitions for the 7404 self-test sequencer:
// state encoding and the fixed pattern set.
package hex_bist_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    function automatic int num_patterns(input int lanes);
        return 2 * lanes + 2;
    endfunction

    // 0: zeros, 1: ones, then walking one, then walking zero
    function automatic logic [7:0] pattern(input int idx, input int lanes);
        logic [7:0] ones;
        logic [7:0] v;
        ones = 8'((1 << lanes) - 1);
        v    = '0;
        if (idx == 1) begin
            v = ones;
        end else if (idx >= 2 && idx < lanes + 2) begin
            v = 8'(1 << (idx - 2));
        end else if (idx >= lanes + 2 && idx < 2 * lanes + 2) begin
            v = ones & ~8'(1 << (idx - lanes - 2));
        end
        return v;
    endfunction

endpackage

// File: rtl/hex_inverter_bist_if.sv
// Test-controller side of the sequencer: start/abort in,
// status and result out.
interface hex_inverter_bist_if #(
    parameter int LANES  = 6,
    parameter int PIDX_W = 4
);
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              pass;
    logic [PIDX_W-1:0] fail_pattern;
    logic [LANES-1:0]  fail_mask;

    modport master (
        output start, abort,
        input  busy, done, pass, fail_pattern, fail_mask
    );

    modport slave (
        input  start, abort,
        output busy, done, pass, fail_pattern, fail_mask
    );
endinterface

// File: rtl/hex_inverter_bist_pattern_gen.sv
// Combinational pattern lookup: index in, lane vector out.
module hex_bist_pattern_gen
    import hex_bist_pkg::*;
#(
    parameter int LANES  = 6,
    parameter int PIDX_W = 4
) (
    input  logic [PIDX_W-1:0] idx,
    output logic [LANES-1:0]  pat
);
    logic [7:0] full;

    always_comb begin
        full = pattern(int'(idx), LANES);
        pat  = full[LANES-1:0];
    end
endmodule

// File: rtl/hex_inverter_bist.sv
// Self-test sequencer for one 7404: drives patterns, waits a
// settle time, checks Y == ~A, stops on the first failure.
module hex_inverter_bist
    import hex_bist_pkg::*;
#(
    parameter int LANES         = 6,
    parameter int SETTLE_CYCLES = 4,
    parameter int PIDX_W        = 4
) (
    input  logic                clk,
    input  logic                reset,
    hex_inverter_bist_if.slave  ctl,
    output logic [LANES-1:0]    a_out,
    input  logic [LANES-1:0]    y_in
);
    localparam int CNT_W =
        (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [PIDX_W-1:0] P_LAST   =
        PIDX_W'(num_patterns(LANES) - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PIDX_W-1:0] p_q, p_d;
    logic [LANES-1:0]  a_q, a_d;
    logic              pass_q, pass_d;
    logic [PIDX_W-1:0] fp_q, fp_d;
    logic [LANES-1:0]  fm_q, fm_d;

    logic [PIDX_W-1:0] pidx;
    logic [LANES-1:0]  pat_next;
    logic [LANES-1:0]  mismatch;

    // Only CHECK advances the index; a fresh start always begins at 0
    assign pidx = (state_q == S_CHECK) ? p_q + PIDX_W'(1) : '0;

    hex_bist_pattern_gen #(
        .LANES  (LANES),
        .PIDX_W (PIDX_W)
    ) u_pat (
        .idx (pidx),
        .pat (pat_next)
    );

    // A good inverter never shows Y equal to A
    assign mismatch = ~(y_in ^ a_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        a_d     = a_q;
        pass_d  = pass_q;
        fp_d    = fp_q;
        fm_d    = fm_q;
        if (ctl.abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            p_d     = '0;
            a_d     = '0;
            pass_d  = 1'b0;
            fp_d    = '0;
            fm_d    = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    a_d = '0;
                    if (ctl.start) begin
                        state_d = S_SETTLE;
                        a_d     = pat_next;
                        p_d     = '0;
                        cnt_d   = CNT_INIT;
                        pass_d  = 1'b0;
                        fp_d    = '0;
                        fm_d    = '0;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                    else             state_d = S_CHECK;
                end
                S_CHECK: begin
                    if (mismatch != '0) begin
                        state_d = S_DONE;
                        fp_d    = p_q;
                        fm_d    = mismatch;
                        pass_d  = 1'b0;
                        a_d     = '0;
                    end else if (p_q != P_LAST) begin
                        state_d = S_SETTLE;
                        p_d     = p_q + PIDX_W'(1);
                        a_d     = pat_next;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = S_DONE;
                        pass_d  = 1'b1;
                        a_d     = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            a_q     <= '0;
            pass_q  <= 1'b0;
            fp_q    <= '0;
            fm_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            a_q     <= a_d;
            pass_q  <= pass_d;
            fp_q    <= fp_d;
            fm_q    <= fm_d;
        end
    end

    assign a_out            = a_q;
    assign ctl.busy         = (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign ctl.done         = (state_q == S_DONE);
    assign ctl.pass         = pass_q;
    assign ctl.fail_pattern = fp_q;
    assign ctl.fail_mask    = fm_q;
endmodule
